// File: rtl/console_seq_if.sv
// rtl/console_seq_if.sv - front panel, decoder handshake and datapath control bundle for console_seq
// step_mode exists only when CONSOLE_SEQ_SINGLE_STEP_EN is defined.
interface console_seq_if #(
    parameter int NREG = 4
);
    localparam int SELW = $clog2(NREG);

    logic            qd;
    logic            swc;
    logic            swb;
    logic            swa;
    logic            short_req;
    logic            long_req;
    logic            halt_req;
`ifdef CONSOLE_SEQ_SINGLE_STEP_EN
    logic            step_mode;
`endif
    logic            w1;
    logic            w2;
    logic            w3;
    logic            st0;
    logic            run_en;
    logic [SELW-1:0] sel;
    logic            sbus;
    logic            mbus;
    logic            lar;
    logic            arinc;
    logic            memw;
    logic            drw;
    logic            lpc;
    logic            selctl;
    logic            stop;

    modport master (
        input  qd, swc, swb, swa, short_req, long_req, halt_req,
`ifdef CONSOLE_SEQ_SINGLE_STEP_EN
        input  step_mode,
`endif
        output w1, w2, w3, st0, run_en, sel,
        output sbus, mbus, lar, arinc, memw, drw, lpc, selctl, stop
    );

    modport slave (
        output qd, swc, swb, swa, short_req, long_req, halt_req,
`ifdef CONSOLE_SEQ_SINGLE_STEP_EN
        output step_mode,
`endif
        input  w1, w2, w3, st0, run_en, sel,
        input  sbus, mbus, lar, arinc, memw, drw, lpc, selctl, stop
    );
endinterface

// File: rtl/console_seq.sv
// rtl/console_seq.sv - console mode and W1/W2/W3 beat sequencer for the teaching CPU
// Optional single-step run mode: define CONSOLE_SEQ_SINGLE_STEP_EN.
module console_seq #(
    parameter int NREG = 4
) (
    input logic          clk,
    input logic          clr,
    console_seq_if.master bus
);
    localparam int SELW = $clog2(NREG);

    localparam logic [2:0] M_RUN  = 3'b000;
    localparam logic [2:0] M_MEMW = 3'b001;
    localparam logic [2:0] M_MEMR = 3'b010;
    localparam logic [2:0] M_REGR = 3'b011;
    localparam logic [2:0] M_REGW = 3'b100;

    typedef enum logic [1:0] {
        S_HALT = 2'd0,
        S_W1   = 2'd1,
        S_W2   = 2'd2,
        S_W3   = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [2:0]      msw;
    logic            st0;
    logic [SELW-1:0] ridx;
    logic [SELW-1:0] ridx_inc;
    logic [2:0]      sw;
    logic            sw_ok;
    logic            start;
    logic            run_op;
    logic            step_end;
    logic            step_halt;
    logic            halt_ask;

    assign sw       = {bus.swc, bus.swb, bus.swa};
    assign sw_ok    = (sw <= M_REGW);
    assign start    = (state == S_HALT) && bus.qd && sw_ok;
    assign run_op   = (msw == M_RUN) && st0;
    assign ridx_inc = (ridx == SELW'(NREG - 1)) ? '0 : ridx + 1'b1;

`ifdef CONSOLE_SEQ_SINGLE_STEP_EN
    assign halt_ask = bus.halt_req || bus.step_mode;
`else
    assign halt_ask = bus.halt_req;
`endif

    // Console steps and the run setup step always stop; only operating run
    // steps defer to the decoder.
    assign step_halt = run_op ? halt_ask : 1'b1;

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= S_HALT;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        step_end = 1'b0;
        case (state)
            S_HALT: if (start) state_nx = S_W1;
            S_W1: begin
                if (!run_op || bus.short_req) step_end = 1'b1;
                else                          state_nx = S_W2;
            end
            S_W2: begin
                if (bus.long_req) state_nx = S_W3;
                else              step_end = 1'b1;
            end
            S_W3:    step_end = 1'b1;
            default: state_nx = S_HALT;
        endcase
        if (step_end) state_nx = step_halt ? S_HALT : S_W1;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            msw  <= M_RUN;
            st0  <= 1'b0;
            ridx <= '0;
        end else if (start) begin
            msw <= sw;
            if (sw != msw) begin
                st0  <= 1'b0;
                ridx <= '0;
            end
        end else if (step_end) begin
            // Register modes walk the file; memory and run modes leave setup.
            if (msw == M_REGW || msw == M_REGR) ridx <= ridx_inc;
            else                                st0  <= 1'b1;
        end
    end

    always_comb begin
        bus.w1     = 1'b0;
        bus.w2     = 1'b0;
        bus.w3     = 1'b0;
        bus.st0    = st0;
        bus.run_en = 1'b0;
        bus.sel    = '0;
        bus.sbus   = 1'b0;
        bus.mbus   = 1'b0;
        bus.lar    = 1'b0;
        bus.arinc  = 1'b0;
        bus.memw   = 1'b0;
        bus.drw    = 1'b0;
        bus.lpc    = 1'b0;
        bus.selctl = 1'b0;
        bus.stop   = 1'b0;
        case (state)
            S_HALT: bus.stop = 1'b1;
            S_W1: begin
                bus.w1 = 1'b1;
                case (msw)
                    M_REGW: begin
                        bus.sel    = ridx;
                        bus.sbus   = 1'b1;
                        bus.drw    = 1'b1;
                        bus.selctl = 1'b1;
                        bus.stop   = 1'b1;
                    end
                    M_REGR: begin
                        bus.sel    = ridx;
                        bus.selctl = 1'b1;
                        bus.stop   = 1'b1;
                    end
                    M_MEMR, M_MEMW: begin
                        bus.selctl = 1'b1;
                        bus.stop   = 1'b1;
                        if (!st0) begin
                            bus.sbus = 1'b1;
                            bus.lar  = 1'b1;
                        end else if (msw == M_MEMR) begin
                            bus.mbus  = 1'b1;
                            bus.arinc = 1'b1;
                        end else begin
                            bus.sbus  = 1'b1;
                            bus.memw  = 1'b1;
                            bus.arinc = 1'b1;
                        end
                    end
                    default: begin
                        if (!st0) begin
                            bus.sbus = 1'b1;
                            bus.lpc  = 1'b1;
                            bus.stop = 1'b1;
                        end else begin
                            bus.run_en = 1'b1;
                        end
                    end
                endcase
            end
            S_W2: begin
                bus.w2     = 1'b1;
                bus.run_en = run_op;
            end
            S_W3: begin
                bus.w3     = 1'b1;
                bus.run_en = run_op;
            end
            default: bus.stop = 1'b1;
        endcase
    end
endmodule

// File: tb/tb_console_seq.sv
// tb/tb_console_seq.sv - self-checking bench for console_seq with a step-level expected-beat model
module tb_console_seq;
    localparam int NREG = 4;

    localparam logic [8:0] S_HALTV = 9'b000000001;
    localparam logic [8:0] S_REGW  = 9'b100001011;
    localparam logic [8:0] S_REGR  = 9'b000000011;
    localparam logic [8:0] S_MSET  = 9'b101000011;
    localparam logic [8:0] S_MRD   = 9'b010100011;
    localparam logic [8:0] S_MWR   = 9'b100110011;
    localparam logic [8:0] S_RSET  = 9'b100000101;
    localparam logic [8:0] S_NONE  = 9'b000000000;

    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    console_seq_if #(.NREG(NREG)) ifc ();
    console_seq #(.NREG(NREG)) dut (.clk(clk), .clr(clr), .bus(ifc));

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [15:0] expq[$];
    logic [1:0]  drw_sel[$];
    int w1cnt = 0;
    int w2cnt = 0;
    int w3cnt = 0;

    logic [2:0] m_sw  = 3'b000;
    logic       m_st0 = 1'b0;
    int         m_ridx = 0;
    bit         m_ss  = 1'b0;

    logic [15:0] dv;
    assign dv = {ifc.w1, ifc.w2, ifc.w3, ifc.st0, ifc.run_en, ifc.sel,
                 ifc.sbus, ifc.mbus, ifc.lar, ifc.arinc, ifc.memw, ifc.drw,
                 ifc.lpc, ifc.selctl, ifc.stop};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
    endtask

    function automatic logic [15:0] vec(input int beat, input logic s0, input logic ren,
                                        input logic [1:0] sl, input logic [8:0] strb);
        return {beat == 1, beat == 2, beat == 3, s0, ren, sl, strb};
    endfunction

    always @(negedge clk) begin
        if (expq.size() > 0) chk("cycle", {16'h0, dv}, {16'h0, expq.pop_front()});
        if (ifc.drw) drw_sel.push_back(ifc.sel);
        if (ifc.w1) w1cnt++;
        if (ifc.w2) w2cnt++;
        if (ifc.w3) w3cnt++;
    end

    // Inputs set before a tick are seen at its edge; exp is the state after it.
    task automatic tick(input logic [15:0] exp);
        @(posedge clk);
        #1;
        expq.push_back(exp);
    endtask

    task automatic halt_tick();
        tick(vec(0, m_st0, 1'b0, 2'd0, S_HALTV));
    endtask

    task automatic press(input logic [2:0] s);
        logic [8:0] strb;
        logic [1:0] sl;
        {ifc.swc, ifc.swb, ifc.swa} = s;
        ifc.qd = 1'b1;
        if (s > 3'b100) begin
            halt_tick();
            ifc.qd = 1'b0;
            repeat (9) halt_tick();
            return;
        end
        if (s != m_sw) begin
            m_st0  = 1'b0;
            m_ridx = 0;
        end
        m_sw = s;
        sl   = 2'd0;
        case (s)
            3'b100:  begin strb = S_REGW; sl = 2'(m_ridx); end
            3'b011:  begin strb = S_REGR; sl = 2'(m_ridx); end
            3'b010:  strb = m_st0 ? S_MRD : S_MSET;
            3'b001:  strb = m_st0 ? S_MWR : S_MSET;
            default: strb = S_RSET;
        endcase
        tick(vec(1, m_st0, 1'b0, sl, strb));
        ifc.qd = 1'b0;
        if (s == 3'b100 || s == 3'b011) m_ridx = (m_ridx + 1) % NREG;
        else                             m_st0  = 1'b1;
        halt_tick();
    endtask

    // Operating run: instruction i has W1 only if sh, W1..W3 if lo, else W1,W2.
    task automatic run(input int n, input logic [7:0] sh, input logic [7:0] lo,
                       input logic [7:0] ha, input logic noise);
        int nb;
        {ifc.swc, ifc.swb, ifc.swa} = 3'b000;
        ifc.qd = 1'b1;
        for (int i = 0; i < n; i++) begin
            nb = sh[i] ? 1 : (lo[i] ? 3 : 2);
            for (int b = 1; b <= nb; b++) begin
                tick(vec(b, 1'b1, 1'b1, 2'd0, S_NONE));
                ifc.qd        = noise;
                ifc.short_req = sh[i];
                ifc.long_req  = lo[i];
                ifc.halt_req  = ha[i];
            end
            if (ha[i] || m_ss) begin
                halt_tick();
                break;
            end
        end
        ifc.qd        = 1'b0;
        ifc.short_req = 1'b0;
        ifc.long_req  = 1'b0;
        ifc.halt_req  = 1'b0;
        halt_tick();
    endtask

    int b1, b2, b3;
    logic [1:0] sel_lit [5];

    initial begin
        sel_lit = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        clr = 1'b1;
        ifc.qd = 1'b0;
        {ifc.swc, ifc.swb, ifc.swa} = 3'b000;
        ifc.short_req = 1'b0;
        ifc.long_req  = 1'b0;
        ifc.halt_req  = 1'b0;
`ifdef CONSOLE_SEQ_SINGLE_STEP_EN
        ifc.step_mode = 1'b0;
`endif
        halt_tick();
        ifc.qd = 1'b1;
        halt_tick();
        chk("reset_stop", {31'h0, ifc.stop}, 32'd1);
        chk("reset_st0", {31'h0, ifc.st0}, 32'd0);
        ifc.qd = 1'b0;
        clr = 1'b0;
        halt_tick();

        repeat (5) press(3'b100);
        chk("drw_count", drw_sel.size(), 32'd5);
        for (int k = 0; k < 5; k++)
            if (k < drw_sel.size()) chk("drw_sel", {30'h0, drw_sel[k]}, {30'h0, sel_lit[k]});

        press(3'b011);
        repeat (4) press(3'b001);
        press(3'b010);
        press(3'b010);

        press(3'b000);
        b1 = w1cnt; b2 = w2cnt; b3 = w3cnt;
        run(3, 8'b010, 8'b001, 8'b100, 1'b1);
        chk("run_w1", w1cnt - b1, 32'd3);
        chk("run_w2", w2cnt - b2, 32'd2);
        chk("run_w3", w3cnt - b3, 32'd1);

        ifc.qd = 1'b1;
        tick(vec(1, 1'b1, 1'b1, 2'd0, S_NONE));
        ifc.qd = 1'b0;
        tick(vec(2, 1'b1, 1'b1, 2'd0, S_NONE));
        clr = 1'b1;
        ifc.long_req = 1'b1;
        m_st0 = 1'b0;
        m_ridx = 0;
        halt_tick();
        chk("clr_run_en", {31'h0, ifc.run_en}, 32'd0);
        clr = 1'b0;
        ifc.long_req = 1'b0;
        repeat (2) halt_tick();

        press(3'b111);
        press(3'b100);
        chk("after_bad_sw_sel", {30'h0, drw_sel[drw_sel.size()-1]}, 32'd0);

`ifdef CONSOLE_SEQ_SINGLE_STEP_EN
        press(3'b000);
        ifc.step_mode = 1'b1;
        m_ss = 1'b1;
        b1 = w1cnt;
        run(2, 8'b00, 8'b01, 8'b00, 1'b0);
        run(2, 8'b01, 8'b00, 8'b00, 1'b0);
        run(1, 8'b0, 8'b0, 8'b0, 1'b0);
        chk("ss_w1", w1cnt - b1, 32'd3);
        ifc.step_mode = 1'b0;
        m_ss = 1'b0;
`endif

        repeat (3) halt_tick();
        @(negedge clk);
        #1;
        chk("queue_drained", expq.size(), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/console_seq.md
Name: console_seq

Overview:
- Parametrised, clocked console and beat sequencer for the teaching CPU.
- Generates the W1/W2/W3 beats internally.
- Drives the console modes: register write, register read, memory read, memory write, program start. Register count is configurable.
- In run mode, hands beats to the external instruction decoder and obeys its short/long/halt requests.

Parameters:
- NREG, 4, number of console-addressable registers (power of 2, >=2); SELW = clog2(NREG) is a localparam.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- clr  input  1  synchronous, active-high reset.
- qd  input  1  one-cycle start pulse from the front panel (already debounced).
- swc, swb, swa  input  1 each  console mode; sw = {swc,swb,swa}.
- short_req  input  1  decoder: current instruction ends after W1 (sampled in W1).
- long_req  input  1  decoder: current instruction needs W3 (sampled in W2).
- halt_req  input  1  decoder: stop after current instruction (sampled on last beat).
- w1, w2, w3  output  1 each  one-hot beat indicators.
- st0  output  1  phase flag: 0 = setup step, 1 = operate steps.
- run_en  output  1  high during run-mode beats with st0=1.
- sel  output  SELW  register select.
- sbus, mbus, lar, arinc, memw, drw, lpc, selctl, stop  output  1 each  datapath controls.

Behaviour:
- Reset (clr=1 at edge):
  - state HALT; st0=0; ridx=0.
  - All outputs 0 except stop=1.
  - Reset in mid-step aborts the step; no write strobe appears in the following cycle.
- States: HALT, W1, W2, W3. Each beat lasts exactly one clk.
  - HALT: stop=1. Advance to W1 only on qd.
  - W1 -> W2, except: console modes end after W1 (short); run mode with short_req ends after W1.
  - W2 -> W3 only if run mode and long_req; otherwise the step ends.
  - W3: the step always ends.
- End of step:
  - Step's stop flag set -> HALT.
  - Otherwise -> W1 of the next step (back-to-back, no gap).
- sw is latched on the qd that leaves HALT. A latched sw differing from the previous latched sw clears st0 and ridx before W1.
- Outputs are decoded from state and are stable for the whole beat.
- Mode 100, register write (one register per step):
  - W1: sel=ridx, sbus=1, drw=1, selctl=1.
  - Step stops. End of step: ridx=ridx+1, wrapping NREG-1 -> 0.
- Mode 011, register read:
  - W1: sel=ridx, selctl=1, no drw.
  - Step stops. ridx increments and wraps as in mode 100.
- Mode 010, memory read:
  - st0=0, W1: sbus=1, lar=1, selctl=1; st0 set at end of step.
  - st0=1, W1: mbus=1, arinc=1, selctl=1.
  - Every step stops.
- Mode 001, memory write:
  - st0=0: as mode 010.
  - st0=1, W1: sbus=1, memw=1, arinc=1, selctl=1.
  - Every step stops.
- Mode 000, run:
  - st0=0, W1: sbus=1, lpc=1, stop=1; st0 set at end of step.
  - st0=1: run_en=1 on every beat; stop=0.
  - Steps chain continuously until halt_req is seen on a step's last beat. Then -> HALT, with st0 kept at 1.
  - qd in HALT resumes run with st0=1.
- Other sw codes: remain HALT (stop=1, all strobes 0); qd is ignored.
- qd outside HALT is ignored.
- Simultaneous clr and qd: clr wins.

Optional Feature:
- Macro: CONSOLE_SEQ_SINGLE_STEP_EN.
- When defined:
  - Adds input step_mode (1 bit).
  - In run mode with st0=1 and step_mode=1, every instruction ends in HALT, as if halt_req=1. qd executes the next instruction.
- When undefined: port absent; run mode behaves only as specified above.

Test Plan:
- NREG=4, mode 100, five qd pulses -> drw high for exactly one W1 each; sel sequence 0,1,2,3,0; stop=1 between pulses.
- Mode 001:
  - qd -> lar=1, st0 becomes 1.
  - Three more qd -> memw=1 and arinc=1 in each W1; no lar.
  - Switching to 010 then qd -> st0 back to 0, lar=1.
- Mode 000:
  - First qd -> lpc=1.
  - Second qd, with long_req=1 on the first instruction and short_req=1 on the second -> beats W1,W2,W3,W1,W2? No: beats are W1,W2,W3 then W1 only.
  - halt_req on the third instruction -> stop=1 after its last beat.
- clr asserted during W2 of a run instruction -> next cycle HALT, st0=0, run_en=0, all strobes 0.
- sw=111 with qd -> remains HALT; no strobes for 10 cycles.
- CONSOLE_SEQ_SINGLE_STEP_EN, step_mode=1: each qd in run yields exactly one instruction's beats, then HALT.
